// File: rtl/mux_scan_nx1_pkg.sv
// Shared types and constants for the N:1 scanning channel multiplexer.
package mux_scan_pkg;

  // Sampler sequencing: idle, dwell countdown, holding a sample for the consumer.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StPresent = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_nx1_if.sv
// Valid/ready sample stream carrying the sampled data and its channel index.
interface mux_scan_nx1_if #(
  parameter int unsigned DW   = 1,
  parameter int unsigned SELW = 4
);
  logic [DW-1:0]   out_data;
  logic [SELW-1:0] out_ch;
  logic            out_valid;
  logic            out_ready;

  modport master (output out_data, output out_ch, output out_valid, input out_ready);
  modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/mux_scan_nx1_rr_next_ch.sv
// Round-robin successor: lowest enabled channel above cur_ch, wrapping to 0.
module rr_next_ch #(
  parameter int unsigned NCH  = 16,
  parameter int unsigned SELW = 4
) (
  input  logic [NCH-1:0]  ch_en,
  input  logic [SELW-1:0] cur_ch,
  output logic [SELW-1:0] next_ch,
  output logic            any_en
);

  logic [2*NCH-1:0] dbl;
  logic [2*NCH-1:0] shifted;
  logic [NCH-1:0]   rot;
  int               off;
  int               sum;

  // Rotate so bit 0 is the channel after cur_ch, then take the lowest set bit.
  always_comb begin
    dbl     = {ch_en, ch_en};
    shifted = dbl >> (int'(cur_ch) + 1);
    rot     = shifted[NCH-1:0];
    // Bit NCH-1 of rot is cur_ch itself, so a lone enabled channel maps to itself.
    off     = int'(NCH) - 1;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = int'(cur_ch) + 1 + off;
    if (sum >= int'(NCH)) sum = sum - int'(NCH);
    next_ch = SELW'(sum);
    any_en  = |ch_en;
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel sampler with manual select and round-robin scan modes.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter int unsigned NCH     = 16,
  parameter int unsigned DW      = 1,
  parameter int unsigned SELW    = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*DW-1:0]  in_data,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic               sel_load,
  input  logic [NCH-1:0]     ch_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel_err,
  mux_scan_nx1_if.master     out_if
);

  state_e             state_q, state_d;
  logic [SELW-1:0]    cur_ch_q, cur_ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]      data_q, data_d;
  logic [SELW-1:0]    och_q, och_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [SELW-1:0] next_ch;
  logic            any_en;
  logic            sel_ok;
  logic            load;
  logic            hs;
  logic [DW-1:0]   chan;

  rr_next_ch #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_next_ch (
    .ch_en   (ch_en),
    .cur_ch  (cur_ch_q),
    .next_ch (next_ch),
    .any_en  (any_en)
  );

  assign sel_ok = 32'(sel) < NCH;
  assign load   = sel_load && sel_ok;
  assign hs     = valid_q && out_if.out_ready;
  assign chan   = in_data[int'(cur_ch_q)*DW +: DW];

  // Next-state: dwell countdown, capture, handshake and channel advance.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = load ? sel : cur_ch_q;  // a valid load always beats an advance
    cnt_d    = cnt_q;
    data_d   = data_q;
    och_d    = och_q;
    valid_d  = valid_q;
    err_d    = sel_load && !sel_ok;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (mode == MODE_MANUAL || any_en) begin
          state_d = StWait;
          cnt_d   = dwell;
          if (mode == MODE_SCAN && !ch_en[cur_ch_q] && !load) cur_ch_d = next_ch;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          data_d  = chan;
          och_d   = cur_ch_q;
          valid_d = 1'b1;
          state_d = StPresent;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPresent: begin
        if (hs) begin
          valid_d = 1'b0;
          if (mode == MODE_SCAN && !any_en) begin
            state_d = StIdle;
          end else begin
            state_d = StWait;
            cnt_d   = dwell;
            if (mode == MODE_SCAN && !load) cur_ch_d = next_ch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops the held sample immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cur_ch_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      och_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      och_q    <= och_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_ch    = och_q;
  assign out_if.out_valid = valid_q;
  assign sel_err          = err_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Bench for mux_scan_nx1: directed table, scan/stall/reset sequences, random vs model.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        mode;
  logic [3:0]  sel;
  logic        sel_load;
  logic [15:0] ch_en;
  logic [7:0]  dwell;
  logic        sel_err;

  logic [11:0] b_in;
  logic        b_mode;
  logic [3:0]  b_sel;
  logic        b_load;
  logic [11:0] b_en;
  logic [7:0]  b_dwell;
  logic        b_err;

  mux_scan_nx1_if #(.DW(1), .SELW(4)) a_if ();
  mux_scan_nx1_if #(.DW(1), .SELW(4)) b_if ();

  mux_scan_nx1 #(.NCH(16), .DW(1), .SELW(4), .DWELL_W(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .mode     (mode),
    .sel      (sel),
    .sel_load (sel_load),
    .ch_en    (ch_en),
    .dwell    (dwell),
    .sel_err  (sel_err),
    .out_if   (a_if)
  );

  mux_scan_nx1 #(.NCH(12), .DW(1), .SELW(4), .DWELL_W(8)) u_dut12 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (b_in),
    .mode     (b_mode),
    .sel      (b_sel),
    .sel_load (b_load),
    .ch_en    (b_en),
    .dwell    (b_dwell),
    .sel_err  (b_err),
    .out_if   (b_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model of the 16-channel instance.
  bit m_valid, m_busy, m_data, m_err;
  int m_ch, m_cur, m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_en(input int cur, input logic [15:0] en);
    for (int k = 1; k <= 16; k++) begin
      if (en[(cur + k) % 16]) return (cur + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_data = 0; m_err = 0;
    m_ch = 0; m_cur = 0; m_cnt = 0;
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare all outputs.
  task automatic step();
    bit hs, load, scan, d;
    int nx, new_cur, dw;
    logic [15:0] en;
    hs   = m_valid && a_if.out_ready;
    load = sel_load;  // every 4-bit sel is a legal channel here
    scan = mode;
    en   = ch_en;
    dw   = int'(dwell);
    d    = in_data[m_cur];
    nx   = next_en(m_cur, en);
    @(posedge clk);
    cyc++;
    new_cur = load ? int'(sel) : m_cur;
    m_err   = 0;
    if (m_valid) begin
      if (hs) begin
        m_valid = 0;
        if (scan && en == 16'h0) begin
          m_busy = 0;
        end else begin
          m_busy = 1;
          m_cnt  = dw;
          if (scan && !load) new_cur = nx;
        end
      end
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_valid = 1; m_busy = 0; m_data = d; m_ch = m_cur;
      end else begin
        m_cnt--;
      end
    end else if (!scan || en != 16'h0) begin
      m_busy = 1;
      m_cnt  = dw;
      if (scan && !en[m_cur] && !load) new_cur = nx;
    end
    m_cur = new_cur;
    #1;
    check("m_valid", a_if.out_valid, m_valid);
    check("m_data", a_if.out_data, m_data);
    check("m_ch", a_if.out_ch, m_ch);
    check("m_sel_err", sel_err, m_err);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!a_if.out_valid && n < budget) begin
      step();
      n++;
    end
    check({name, "_timeout"}, a_if.out_valid, 1'b1);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before any edge.
  task automatic reset_check(input string name);
    #1 rst_n = 1'b0;
    #1;
    check({name, "_valid"}, a_if.out_valid, 1'b0);
    check({name, "_data"}, a_if.out_data, 1'b0);
    check({name, "_ch"}, a_if.out_ch, 4'd0);
    check({name, "_err"}, sel_err, 1'b0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic       ld;
    logic [3:0] sel;
    logic       v;
    logic [3:0] ch;
    logic       d;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hs_cyc[$];
    int hs_ch[$];
    int exp_seq[5];
    logic [5:0] snap;
    int seen;

    tbl[0] = '{ld: 1'b1, sel: 4'd5, v: 1'b0, ch: 4'd0, d: 1'b0};
    tbl[1] = '{ld: 1'b0, sel: 4'd0, v: 1'b1, ch: 4'd5, d: 1'b1};
    tbl[2] = '{ld: 1'b0, sel: 4'd0, v: 1'b0, ch: 4'd5, d: 1'b1};
    tbl[3] = '{ld: 1'b0, sel: 4'd0, v: 1'b1, ch: 4'd5, d: 1'b1};
    tbl[4] = '{ld: 1'b0, sel: 4'd0, v: 1'b0, ch: 4'd5, d: 1'b1};
    tbl[5] = '{ld: 1'b0, sel: 4'd0, v: 1'b1, ch: 4'd5, d: 1'b1};
    exp_seq = '{0, 4, 7, 0, 4};

    rst_n = 1'b0;
    in_data = 16'h0020; mode = 1'b0; sel = 4'd0; sel_load = 1'b0;
    ch_en = 16'h0; dwell = 8'd0; a_if.out_ready = 1'b1;
    b_in = 12'h808; b_mode = 1'b0; b_sel = 4'd0; b_load = 1'b0;
    b_en = 12'h0; b_dwell = 8'd0; b_if.out_ready = 1'b1;
    model_reset();

    // Outputs held at zero while reset is asserted, across clock edges.
    #2;
    check("rst_valid", a_if.out_valid, 1'b0);
    check("rst_data", a_if.out_data, 1'b0);
    check("rst_ch", a_if.out_ch, 4'd0);
    check("rst_err", sel_err, 1'b0);
    #15;
    check("rst_valid_edge", a_if.out_valid, 1'b0);
    check("rst_b_valid", b_if.out_valid, 1'b0);
    #5 rst_n = 1'b1;

    // Manual select of channel 5 with dwell 0: a sample every second cycle.
    for (int i = 0; i < 6; i++) begin
      sel_load = tbl[i].ld;
      sel      = tbl[i].sel;
      step();
      check($sformatf("tbl%0d_valid", i), a_if.out_valid, tbl[i].v);
      check($sformatf("tbl%0d_ch", i), a_if.out_ch, tbl[i].ch);
      check($sformatf("tbl%0d_data", i), a_if.out_data, tbl[i].d);
    end
    sel_load = 1'b0;

    // Scan over channels 0, 4, 7 with dwell 3.
    reset_check("rst_pre_scan");
    mode = 1'b1; ch_en = 16'h0091; dwell = 8'd3; in_data = 16'h0090;
    for (int i = 0; i < 60 && hs_ch.size() < 5; i++) begin
      step();
      if (a_if.out_valid && a_if.out_ready) begin
        hs_cyc.push_back(cyc);
        hs_ch.push_back(int'(a_if.out_ch));
      end
    end
    check("scan_hs_count", hs_ch.size(), 5);
    for (int k = 0; k < hs_ch.size(); k++) begin
      check($sformatf("scan_ch%0d", k), hs_ch[k], exp_seq[k]);
      if (k > 0) check($sformatf("scan_gap%0d", k), hs_cyc[k] - hs_cyc[k-1], 5);
    end

    // Consumer stall for 10 cycles: sample must hold, then scan resumes without skipping.
    step();
    wait_valid("stall_pre", 10);
    check("stall_ch", a_if.out_ch, 4'd7);
    a_if.out_ready = 1'b0;
    snap = {a_if.out_valid, a_if.out_data, a_if.out_ch};
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), {a_if.out_valid, a_if.out_data, a_if.out_ch}, snap);
    end
    a_if.out_ready = 1'b1;
    step();
    wait_valid("stall_post", 10);
    check("stall_resume_ch", a_if.out_ch, 4'd0);

    // Clearing the mask during a held sample: it completes, then the block idles.
    ch_en = 16'h0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("idle_valid%0d", i), a_if.out_valid, 1'b0);
    end
    ch_en = 16'h0100;
    wait_valid("restart", 20);
    check("restart_ch", a_if.out_ch, 4'd8);

    // A load coinciding with the handshake overrides the round-robin advance.
    ch_en = 16'h0091; sel_load = 1'b1; sel = 4'd2;
    step();
    sel_load = 1'b0;
    wait_valid("coinc", 20);
    check("coinc_ch", a_if.out_ch, 4'd2);

    // 12-channel instance: out-of-range load flags an error and is otherwise ignored.
    b_load = 1'b1; b_sel = 4'd3;
    step();
    b_sel = 4'd13;
    step();
    b_load = 1'b0;
    check("b_err_pulse", b_err, 1'b1);
    step();
    check("b_err_clear", b_err, 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (b_if.out_valid) begin
        seen++;
        check($sformatf("b_keep_ch%0d", i), b_if.out_ch, 4'd3);
      end
    end
    check("b_seen_valid", seen, 2);

    // Reset during the dwell countdown, then during a held sample.
    mode = 1'b0; dwell = 8'd20; in_data = 16'h0201; sel_load = 1'b1; sel = 4'd9;
    step();
    sel_load = 1'b0;
    wait_valid("rw_cap", 40);
    check("rw_ch", a_if.out_ch, 4'd9);
    for (int i = 0; i < 4; i++) step();
    reset_check("rst_mid_wait");
    dwell = 8'd2; a_if.out_ready = 1'b0;
    wait_valid("rw_first", 10);
    check("rw_first_ch", a_if.out_ch, 4'd0);
    check("rw_first_data", a_if.out_data, 1'b1);
    step();
    reset_check("rst_mid_present");
    a_if.out_ready = 1'b1;
    wait_valid("rp_first", 10);
    check("rp_first_ch", a_if.out_ch, 4'd0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_data        = 16'($urandom);
      a_if.out_ready = ($urandom_range(0, 2) != 0);
      sel_load       = ($urandom_range(0, 15) == 0);
      sel            = 4'($urandom);
      if ($urandom_range(0, 19) == 0) ch_en = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
